// File: rtl/tff_stream_pkg.sv
// ============================================================================
// tff_stream_pkg : shared types and constants for the TFF stream decoder
// Revision: 1.0
// ============================================================================
`default_nettype none

package tff_stream_pkg;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    DATA = 1'b1
  } state_t;

  localparam int          DEFAULT_DATA_W    = 8;
  localparam logic [7:0]  DEFAULT_SYNC_WORD = 8'h7E;

  // Bit counter must index 0..DATA_W-1; a 1-bit word still needs one bit.
  function automatic int bit_cnt_width(input int dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

  localparam int DEFAULT_CNT_W = bit_cnt_width(DEFAULT_DATA_W);

endpackage

`default_nettype wire

// File: rtl/tff_edge_decoder.sv
// ============================================================================
// tff_edge_decoder : recovers T-input bits from a T flip-flop Q line
// Revision: 1.0
// ============================================================================
`default_nettype none

module tff_edge_decoder (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  input  logic line_valid,
  output logic bit_out
);

  logic prev_level;

  // Matches a T flip-flop reset to Q=0; idle cycles leave the level untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_level <= 1'b0;
    end else if (line_valid) begin
      prev_level <= line_in;
    end
  end

  assign bit_out = line_in ^ prev_level;

endmodule

`default_nettype wire

// File: rtl/tff_stream_decoder.sv
// ============================================================================
// tff_stream_decoder : sync-word framed, LSB-first toggle-line word decoder
// Revision: 1.0
// ============================================================================
`default_nettype none

module tff_stream_decoder
  import tff_stream_pkg::*;
#(
  parameter int                DATA_W    = DEFAULT_DATA_W,
  parameter logic [DATA_W-1:0] SYNC_WORD = DATA_W'(DEFAULT_SYNC_WORD)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_in,
  input  logic              line_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              in_frame,
  output logic              frame_done,
  output logic              frame_err,
  output logic [7:0]        word_count
);

  localparam int              CNT_W    = bit_cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t            state;
  state_t            state_next;
  logic              bit_dec;
  logic [DATA_W-1:0] window;
  logic [DATA_W-1:0] window_shifted;
  logic [CNT_W-1:0]  bit_cnt;
  logic              sync_hit;
  logic              word_last;
  logic              done_set;
  logic              err_set;
  logic              frame_end;

  tff_edge_decoder u_edge (
    .clk        (clk),
    .reset      (reset),
    .line_in    (line_in),
    .line_valid (line_valid),
    .bit_out    (bit_dec)
  );

  // Window including the bit being sampled this cycle.
  assign window_shifted = {bit_dec, window[DATA_W-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HUNT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    sync_hit   = 1'b0;
    word_last  = 1'b0;
    done_set   = 1'b0;
    err_set    = 1'b0;
    frame_end  = 1'b0;
    case (state)
      HUNT: begin
        if (line_valid && (window_shifted == SYNC_WORD)) begin
          sync_hit   = 1'b1;
          state_next = DATA;
        end
      end
      DATA: begin
        if (line_valid) begin
          word_last = (bit_cnt == LAST_BIT);
        end else begin
          frame_end  = 1'b1;
          done_set   = (bit_cnt == '0);
          err_set    = (bit_cnt != '0);
          state_next = HUNT;
        end
      end
      default: state_next = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      window     <= '0;
      bit_cnt    <= '0;
      data_out   <= '0;
      word_count <= '0;
      data_valid <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= word_last;
      frame_done <= done_set;
      frame_err  <= err_set;

      // Clearing on frame end keeps a payload tail from aliasing into a sync.
      if (line_valid) begin
        window <= window_shifted;
      end else if (frame_end) begin
        window <= '0;
      end

      if (sync_hit || frame_end || word_last) begin
        bit_cnt <= '0;
      end else if ((state == DATA) && line_valid) begin
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (word_last) begin
        data_out <= window_shifted;
      end

      if (sync_hit) begin
        word_count <= '0;
      end else if (word_last && (word_count != 8'hFF)) begin
        word_count <= word_count + 8'd1;
      end
    end
  end

  assign in_frame = (state == DATA);

endmodule

`default_nettype wire
